// File: rtl/inst_loader_if.sv
// Byte-stream handshake and Inst_mem write port shared by the boot loader and its peers.
// The master view is the loader: it sinks stream bytes and drives the memory write port.
interface inst_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_loader.sv
// Boot loader: packs a little-endian byte stream into words written to Inst_mem from
// address 0 while the core is held in reset, then releases the core after a short delay.
module inst_loader #(
    parameter int DEPTH       = 256,
    parameter int LEN_W       = 9,
    parameter int RELEASE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  load_len,
    inst_loader_if.master     bus,
    output logic              rst_n_cpu,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam int DLY_W = $clog2(RELEASE_DLY + 1) + 1;

    typedef enum logic [2:0] {IDLE, RECV, WRITE, WAIT, RUN} state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] index;
    logic [LEN_W-1:0] len_sel;
    logic [1:0]       bcnt;
    logic [23:0]      word_lo;
    logic [DLY_W-1:0] dly_cnt;
    logic             accept;
    logic             launch;
    logic             last_word;
    logic             dly_done;
    logic             ready_d;
    logic             wr_en_d;
    logic             busy_d;
    logic             run_d;

    // byte_ready is a register that is high exactly while in RECV
    assign accept    = bus.byte_valid && bus.byte_ready;
    assign launch    = start && ((state == IDLE) || (state == RUN));
    assign len_sel   = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
    assign last_word = (index + LEN_W'(1)) == len_q;
    assign dly_done  = dly_cnt == DLY_W'(RELEASE_DLY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            len_q          <= '0;
            index          <= '0;
            bcnt           <= '0;
            word_lo        <= '0;
            dly_cnt        <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_wr_en  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            rst_n_cpu      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            checksum       <= '0;
        end else begin
            state          <= state_nx;
            bus.byte_ready <= ready_d;
            bus.mem_wr_en  <= wr_en_d;
            busy           <= busy_d;
            done           <= run_d;
            rst_n_cpu      <= run_d;
            dly_cnt        <= (state == WAIT) ? dly_cnt + DLY_W'(1) : '0;

            if (launch) begin
                len_q    <= len_sel;
                index    <= '0;
                bcnt     <= '0;
                checksum <= '0;
            end

            // The fourth byte goes straight into mem_wdata so the word is ready in WRITE
            if (accept) begin
                bcnt <= bcnt + 2'd1;
                case (bcnt)
                    2'd0: word_lo[7:0]   <= bus.byte_data;
                    2'd1: word_lo[15:8]  <= bus.byte_data;
                    2'd2: word_lo[23:16] <= bus.byte_data;
                    default: begin
                        bus.mem_wdata <= {bus.byte_data, word_lo};
                        bus.mem_addr  <= 32'({index, 2'b00});
                    end
                endcase
            end

            if (state == WRITE) begin
                checksum <= checksum + bus.mem_wdata;
                index    <= index + LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, RUN: if (launch) state_nx = (len_sel == '0) ? WAIT : RECV;
            RECV:      if (accept && (bcnt == 2'd3)) state_nx = WRITE;
            WRITE:     state_nx = last_word ? WAIT : RECV;
            WAIT:      if (dly_done) state_nx = RUN;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (state_nx == RECV);
        wr_en_d = (state_nx == WRITE);
        busy_d  = (state_nx == RECV) || (state_nx == WRITE) || (state_nx == WAIT);
        run_d   = (state_nx == RUN);
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a queue-based reference model
// of the byte packing, write sequence, checksum and core-release timing.
module tb_inst_loader;

    localparam int DEPTH       = 256;
    localparam int LEN_W       = 9;
    localparam int RELEASE_DLY = 2;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [63:0] wr_q_t[$];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] load_len = '0;
    logic             rst_n_cpu;
    logic             busy;
    logic             done;
    logic [31:0]      checksum;

    inst_loader_if bus_if ();

    inst_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W), .RELEASE_DLY(RELEASE_DLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .load_len  (load_len),
        .bus       (bus_if),
        .rst_n_cpu (rst_n_cpu),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    int      checks = 0;
    int      passes = 0;
    int      timeouts = 0;
    int      cyc = 0;
    int      last_wr_cyc = 0;
    int      rise_cyc = -1;
    int      start_cyc = 0;
    int      rdy_in_wr = 0;
    logic    prev_rc = 1'b0;
    wr_q_t   wlog;
    byte_q_t alog;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: a handshake seen here completes on the following rising edge
    always @(negedge clk) begin
        if (bus_if.mem_wr_en) begin
            wlog.push_back({bus_if.mem_addr, bus_if.mem_wdata});
            last_wr_cyc = cyc;
            if (bus_if.byte_ready) rdy_in_wr++;
        end
        if (bus_if.byte_valid && bus_if.byte_ready && rst_n) alog.push_back(bus_if.byte_data);
        if (rst_n_cpu && !prev_rc) rise_cyc = cyc;
        prev_rc = rst_n_cpu;
        if (start) start_cyc = cyc;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void model(input byte_q_t b, input int len, output wr_q_t w,
                                  output logic [31:0] sum);
        int n;
        logic [31:0] word;
        n = (len > DEPTH) ? DEPTH : len;
        w = {};
        sum = '0;
        for (int i = 0; i < n; i++) begin
            word = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            w.push_back({32'(4 * i), word});
            sum = sum + word;
        end
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // All stimulus tasks start and end just after a rising edge
    task automatic pulse_start(input int len);
        wlog.delete();
        alog.delete();
        rise_cyc = -1;
        load_len = LEN_W'(len);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap_max);
        int n;
        bit ok;
        repeat ($urandom_range(gap_max, 0)) begin
            bus_if.byte_valid = 1'b0;
            bus_if.byte_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = b;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus_if.byte_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) timeouts++;
        bus_if.byte_valid = 1'b0;
    endtask

    task automatic feed(input byte_q_t b, input int gap_max, input bit hold_after_word);
        foreach (b[i]) push_byte(b[i], (hold_after_word && (i % 4 == 0)) ? 0 : gap_max);
    endtask

    task automatic wait_release();
        bit up;
        up = 1'b0;
        for (int n = 0; n < 100 && !up; n++) begin
            @(negedge clk);
            up = rst_n_cpu;
        end
        if (!up) timeouts++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [100:0] outs;
        rst_n = 1'b0;
        start = 1'b1;
        load_len = LEN_W'(5);
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = 8'hA5;
        repeat (5) begin
            @(negedge clk);
            outs = {bus_if.byte_ready, bus_if.mem_wr_en, bus_if.mem_addr, bus_if.mem_wdata,
                    rst_n_cpu, busy, done, checksum};
            checks++;
            if (outs !== '0) $display("FAIL reset_outputs: got %h want 0", outs); else passes++;
        end
        start = 1'b0;
        bus_if.byte_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        byte_q_t b;
        b = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        pulse_start(2);
        checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
        feed(b, 0, 1'b0);
        wait_release();
        checks++;
        if (wlog.size() !== 2) $display("FAIL basic_nwrites: got %0d want 2", wlog.size());
        else passes++;
        if (wlog.size() == 2) begin
            checks++;
            if (wlog[0] !== 64'h00000000_00100513) $display("FAIL basic_w0: got %h want 0000000000100513", wlog[0]);
            else passes++;
            checks++;
            if (wlog[1] !== 64'h00000004_00200593) $display("FAIL basic_w1: got %h want 0000000400200593", wlog[1]);
            else passes++;
        end
        checks++;
        if (checksum !== 32'h00300AA6) $display("FAIL basic_checksum: got %h want 00300aa6", checksum);
        else passes++;
        checks++;
        if (rise_cyc - last_wr_cyc !== RELEASE_DLY + 2)
            $display("FAIL basic_release: got %0d edges want %0d", rise_cyc - last_wr_cyc - 1, RELEASE_DLY + 1);
        else passes++;
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL basic_flags: got done,busy=%b want 10", {done, busy});
        else passes++;
        checks++;
        if (timeouts !== 0) $display("FAIL basic_timeout: got %0d want 0", timeouts); else passes++;
    endtask

    task automatic test_stream(input string name, input int len, input int gap_max, input bit hold);
        byte_q_t     b;
        wr_q_t       exp;
        logic [31:0] sum;
        int          bad;
        b = rand_bytes(4 * len);
        model(b, len, exp, sum);
        rdy_in_wr = 0;
        pulse_start(len);
        feed(b, gap_max, hold);
        wait_release();
        checks++;
        if (alog.size() !== b.size()) $display("FAIL %s_nbytes: got %0d want %0d", name, alog.size(), b.size());
        else passes++;
        bad = 0;
        foreach (b[i]) if (i < alog.size() && alog[i] !== b[i]) bad++;
        checks++;
        if (bad !== 0) $display("FAIL %s_bytes: got %0d differing bytes want 0", name, bad); else passes++;
        checks++;
        if (wlog.size() !== exp.size()) $display("FAIL %s_nwrites: got %0d want %0d", name, wlog.size(), exp.size());
        else passes++;
        foreach (exp[i]) begin
            if (i < wlog.size()) begin
                checks++;
                if (wlog[i] !== exp[i]) $display("FAIL %s_write%0d: got %h want %h", name, i, wlog[i], exp[i]);
                else passes++;
            end
        end
        checks++;
        if (checksum !== sum) $display("FAIL %s_checksum: got %h want %h", name, checksum, sum); else passes++;
        checks++;
        if (rdy_in_wr !== 0) $display("FAIL %s_ready_in_write: got %0d want 0", name, rdy_in_wr); else passes++;
        checks++;
        if (timeouts !== 0) $display("FAIL %s_timeout: got %0d want 0", name, timeouts); else passes++;
    endtask

    task automatic test_zero_length();
        pulse_start(0);
        wait_release();
        checks++;
        if (wlog.size() !== 0) $display("FAIL zero_writes: got %0d want 0", wlog.size()); else passes++;
        checks++;
        if (rise_cyc - start_cyc !== RELEASE_DLY + 2)
            $display("FAIL zero_release: got %0d cycles want %0d", rise_cyc - start_cyc - 1, RELEASE_DLY + 1);
        else passes++;
        checks++;
        if ({checksum, done} !== {32'h0, 1'b1}) $display("FAIL zero_state: got cs=%h done=%b want 0/1", checksum, done);
        else passes++;
    endtask

    task automatic test_clamp();
        byte_q_t     b;
        wr_q_t       exp;
        logic [31:0] sum;
        int          bad;
        b = rand_bytes(1024);
        model(b, 300, exp, sum);
        pulse_start(300);
        feed(b, 0, 1'b0);
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = 8'h5A;
        repeat (10) begin @(posedge clk); #1; end
        bus_if.byte_valid = 1'b0;
        wait_release();
        checks++;
        if (wlog.size() !== DEPTH) $display("FAIL clamp_nwrites: got %0d want %0d", wlog.size(), DEPTH); else passes++;
        checks++;
        if (wlog.size() > 0 && wlog[wlog.size()-1][63:32] !== 32'h3FC)
            $display("FAIL clamp_last_addr: got %h want 000003fc", wlog[wlog.size()-1][63:32]);
        else passes++;
        bad = 0;
        foreach (exp[i]) if (i >= wlog.size() || wlog[i] !== exp[i]) bad++;
        checks++;
        if (bad !== 0) $display("FAIL clamp_writes: got %0d wrong writes want 0", bad); else passes++;
        checks++;
        if (alog.size() !== 1024) $display("FAIL clamp_accepted: got %0d bytes want 1024", alog.size()); else passes++;
        checks++;
        if (checksum !== sum) $display("FAIL clamp_checksum: got %h want %h", checksum, sum); else passes++;
    endtask

    task automatic test_abort_reload();
        logic [100:0] outs;
        byte_q_t      b;
        wr_q_t        exp;
        logic [31:0]  sum;
        pulse_start(3);
        feed(rand_bytes(5), 1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        outs = {bus_if.byte_ready, bus_if.mem_wr_en, bus_if.mem_addr, bus_if.mem_wdata,
                rst_n_cpu, busy, done, checksum};
        checks++;
        if (outs !== '0) $display("FAIL abort_async: got %h want 0", outs); else passes++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        b = rand_bytes(4);
        model(b, 1, exp, sum);
        pulse_start(1);
        feed(b, 2, 1'b0);
        wait_release();
        checks++;
        if (wlog.size() !== 1 || wlog[0] !== exp[0]) $display("FAIL abort_fresh_write: got %0d writes first %h want 1 of %h",
                                                            wlog.size(), (wlog.size() > 0) ? wlog[0] : 64'h0, exp[0]);
        else passes++;

        b = rand_bytes(8);
        model(b, 2, exp, sum);
        pulse_start(2);
        checks++;
        if ({rst_n_cpu, done, busy} !== 3'b001)
            $display("FAIL reload_drop: got rst_n_cpu,done,busy=%b want 001", {rst_n_cpu, done, busy});
        else passes++;
        feed(b, 2, 1'b1);
        wait_release();
        checks++;
        if (wlog.size() !== 2 || wlog[0] !== exp[0] || wlog[1] !== exp[1])
            $display("FAIL reload_writes: got %0d writes want %h %h", wlog.size(), exp[0], exp[1]);
        else passes++;
        checks++;
        if (checksum !== sum) $display("FAIL reload_checksum: got %h want %h", checksum, sum); else passes++;
        checks++;
        if (timeouts !== 0) $display("FAIL reload_timeout: got %0d want 0", timeouts); else passes++;
    endtask

    initial begin
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = '0;
        test_reset();
        test_basic();
        test_stream("stall", $urandom_range(6, 3), 3, 1'b1);
        test_stream("back_to_back", $urandom_range(8, 1), 0, 1'b0);
        test_zero_length();
        test_clamp();
        test_abort_reload();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Boot loader that fills Inst_mem from a byte stream while holding the core in reset, then releases the core. It is the hardware counterpart of the bench-driven preload: it drives Inst_mem's wr_en/addr/Inst_i write port and produces rst_n_cpu for ifu, if_id and id_ex. Bytes arrive on a valid/ready handshake, for example from a UART receiver. They are packed little-endian into 32-bit words and written to consecutive word addresses starting at 0.

Parameters:
DEPTH, 256, instruction memory depth in words (power of 2).
LEN_W, 9, width of load_len; must hold DEPTH.
RELEASE_DLY, 2, cycles between the last write and the deassertion of CPU reset (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse that begins a load.
load_len  input  LEN_W  number of words to load; sampled on start.
byte_valid  input  1  byte_data is valid.
byte_data  input  8  stream byte.
byte_ready  output  1  loader accepts a byte this cycle.
mem_wr_en  output  1  Inst_mem write enable.
mem_addr  output  32  Inst_mem byte address (word-aligned).
mem_wdata  output  32  Inst_mem write data.
rst_n_cpu  output  1  active-low reset to the pipeline.
busy  output  1  load in progress.
done  output  1  load complete and core released.
checksum  output  32  modulo-2^32 sum of the words written in the current load.

Behaviour:
- Reset (asynchronous, active low), all outputs registered:
  - byte_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, rst_n_cpu=0 (core held after power-on), busy=0, done=0, checksum=0.
  - FSM goes to IDLE; the internal word index, byte counter and delay counter clear.
- FSM states: IDLE, RECV, WRITE, WAIT, RUN.
- IDLE:
  - On start: latch len = min(load_len, DEPTH); clear checksum, index and byte counter; busy=1.
  - If len==0 go to WAIT; otherwise go to RECV.
- RECV:
  - byte_ready=1. A byte is accepted on a cycle with byte_valid && byte_ready.
  - The k-th accepted byte (k=0..3) goes to word bits [8k+7:8k].
  - Gaps in byte_valid are allowed with no timeout.
  - On acceptance of the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0; a held byte_valid is not consumed.
  - mem_wr_en=1, mem_addr=index*4, mem_wdata=assembled word.
  - checksum += word, wrapping. index increments.
  - If the new index == len, go to WAIT; otherwise return to RECV.
  - mem_wr_en is 0 in every other state.
- WAIT:
  - Count RELEASE_DLY cycles, then set rst_n_cpu=1, busy=0, done=1 and go to RUN.
  - rst_n_cpu therefore rises RELEASE_DLY+1 clock edges after the edge that captured the final write.
- RUN:
  - Core runs; byte_ready=0.
  - start triggers a reload: on the next edge rst_n_cpu=0 and done=0, then the IDLE start handling applies.
- start is ignored in RECV, WRITE and WAIT.
- mem_addr and mem_wdata hold their last values outside WRITE.
- The last address written is (len-1)*4. With len=DEPTH the index reaches DEPTH and does not wrap into address 0.
- rst_n asserted mid-load aborts the load immediately; memory contents already written are left as-is.

Test Plan:
- Reset: hold rst_n=0 with byte_valid=1 and start=1 -> every output is 0, including rst_n_cpu=0; nothing changes for 5 cycles.
- Basic load, two words:
  - Stimulus: start with load_len=2, then bytes 13 05 10 00 93 05 20 00 back-to-back.
  - Writes: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593, each a 1-cycle mem_wr_en.
  - Release: checksum=0x00300AA6; rst_n_cpu rises 3 edges after the second write; done=1, busy=0.
- Handshake stalls:
  - Stimulus: byte_valid toggles randomly, and one byte is held across a WRITE cycle.
  - Required: byte_ready=0 during WRITE, no byte is duplicated or dropped, and the words match the stream.
- Zero length: load_len=0 -> no mem_wr_en; rst_n_cpu=1 after RELEASE_DLY+1 cycles; checksum=0.
- Clamp: load_len=300 with 1024 bytes -> exactly 256 writes; last mem_addr=0x3FC; bytes after that are not accepted.
- Abort and reload:
  - Stimulus: assert rst_n mid-RECV, then run a fresh 1-word load.
  - Required: outputs reset asynchronously and the new load writes addr 0.
  - Then pulse start in RUN -> rst_n_cpu drops on the next edge and the reload proceeds.
